pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with BOOT/RUN/HALT control FSM.
// Ports: clk, reset (async, active-high), stall, br_taken, br_offset,
//   br_reg, reg_target, halt -> pc, pc_plus4, fetch_valid, halted.
// Macro PC_MISALIGN_TRAP_EN: misaligned br_reg target halts the
//   sequencer and raises misalign_err (port exists only then).
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_offset,
  input  logic        br_reg,
  input  logic [63:0] reg_target,
  input  logic        halt,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] seq_pc;
  logic [63:0] br_tgt;
  logic [63:0] reg_tgt;
  logic        bad_tgt;
  logic        trap;

  assign seq_pc = pc_q + 64'd4;

  // Word offset to byte offset; the top two bits fall off.
  assign br_tgt = pc_q + {br_offset[61:0], 2'b00};

`ifdef PC_MISALIGN_TRAP_EN
  assign reg_tgt = reg_target;
  assign bad_tgt = |reg_target[1:0];
`else
  assign reg_tgt = reg_target & ~64'h3;
  assign bad_tgt = 1'b0;
`endif

  // A bad target only matters when br_reg actually wins priority.
  assign trap = (state_q == RUN) && !halt && !stall
                && br_reg && bad_tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = halt ? HALT : RUN;
      RUN:     if (halt || trap) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (state_q == RUN) begin
      priority case (1'b1)
        halt:     pc_d = pc_q;
        stall:    pc_d = pc_q;
        br_reg:   pc_d = bad_tgt ? pc_q : reg_tgt;
        br_taken: pc_d = br_tgt;
        default:  pc_d = seq_pc;
      endcase
    end
  end

  always_comb begin
    pc          = pc_q;
    pc_plus4    = seq_pc;
    fetch_valid = (state_q == RUN);
    halted      = (state_q == HALT);
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign mis_d = mis_q | trap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign misalign_err = mis_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_offset;
  logic        br_reg;
  logic [63:0] reg_target;
  logic        halt;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .br_reg      (br_reg),
    .reg_target  (reg_target),
    .halt        (halt),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .halted      (halted)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  task automatic clear_ctl();
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_offset  = 64'h0;
    br_reg     = 1'b0;
    reg_target = 64'h0;
    halt       = 1'b0;
  endtask

  // Hold reset one cycle, release on a falling edge (BOOT follows).
  task automatic apply_reset();
    @(negedge clk);
    clear_ctl();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // From RUN, redirect to an aligned address in one cycle.
  task automatic goto_pc(input logic [63:0] a);
    clear_ctl();
    br_reg     = 1'b1;
    reg_target = a;
    @(negedge clk);
    clear_ctl();
  endtask

  task automatic test_reset();
    clear_ctl();
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (pc !== 64'h0)
      $display("FAIL reset_pc got %h want %h", pc, 64'h0);
    else n_pass++;
    n_total++;
    if (pc_plus4 !== 64'h4)
      $display("FAIL reset_pc4 got %h want %h", pc_plus4, 64'h4);
    else n_pass++;
    n_total++;
    if (fetch_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL reset_flags got fv=%b h=%b want 0 0",
               fetch_valid, halted);
    else n_pass++;
  endtask

  task automatic test_boot();
    logic [63:0] exp;
    apply_reset();
    n_total++;
    if (fetch_valid !== 1'b0 || pc !== 64'h0)
      $display("FAIL boot_cyc got fv=%b pc=%h want 0 0",
               fetch_valid, pc);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = 64'(4 * i);
      n_total++;
      if (fetch_valid !== 1'b1 || pc !== exp)
        $display("FAIL boot_seq%0d got fv=%b pc=%h want 1 %h",
                 i, fetch_valid, pc, exp);
      else n_pass++;
    end
  endtask

  task automatic test_boot_ignore();
    apply_reset();
    br_reg     = 1'b1;
    reg_target = 64'h800;
    br_taken   = 1'b1;
    br_offset  = 64'h5;
    stall      = 1'b1;
    @(negedge clk);
    clear_ctl();
    n_total++;
    if (fetch_valid !== 1'b1 || pc !== 64'h0)
      $display("FAIL boot_ign got fv=%b pc=%h want 1 0",
               fetch_valid, pc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (pc !== 64'h4)
      $display("FAIL boot_ign2 got %h want %h", pc, 64'h4);
    else n_pass++;
  endtask

  task automatic test_branch();
    apply_reset();
    @(negedge clk);
    goto_pc(64'h100);
    n_total++;
    if (pc !== 64'h100)
      $display("FAIL br_setup got %h want %h", pc, 64'h100);
    else n_pass++;
    br_taken  = 1'b1;
    br_offset = -64'sd2;
    @(negedge clk);
    n_total++;
    if (pc !== 64'hF8)
      $display("FAIL br_neg got %h want %h", pc, 64'hF8);
    else n_pass++;
    br_offset = 64'h3;
    @(negedge clk);
    n_total++;
    if (pc !== 64'h104)
      $display("FAIL br_pos got %h want %h", pc, 64'h104);
    else n_pass++;
    goto_pc(64'h100);
    br_taken  = 1'b1;
    br_offset = 64'h4000000000000000;
    @(negedge clk);
    clear_ctl();
    n_total++;
    if (pc !== 64'h100)
      $display("FAIL br_shift got %h want %h", pc, 64'h100);
    else n_pass++;
  endtask

  task automatic test_priority();
    goto_pc(64'h40);
    br_reg     = 1'b1;
    reg_target = 64'h800;
    br_taken   = 1'b1;
    br_offset  = 64'h3;
    @(negedge clk);
    n_total++;
    if (pc !== 64'h800)
      $display("FAIL prio_reg got %h want %h", pc, 64'h800);
    else n_pass++;
    goto_pc(64'h40);
    br_reg     = 1'b1;
    reg_target = 64'h800;
    br_taken   = 1'b1;
    br_offset  = 64'h3;
    stall      = 1'b1;
    @(negedge clk);
    n_total++;
    if (pc !== 64'h40 || fetch_valid !== 1'b1)
      $display("FAIL prio_stall got pc=%h fv=%b want 40 1",
               pc, fetch_valid);
    else n_pass++;
    clear_ctl();
    @(negedge clk);
    n_total++;
    if (pc !== 64'h44)
      $display("FAIL prio_lost got %h want %h", pc, 64'h44);
    else n_pass++;
  endtask

  task automatic test_wrap();
    goto_pc(64'hFFFFFFFFFFFFFFFC);
    n_total++;
    if (pc_plus4 !== 64'h0)
      $display("FAIL wrap_p4 got %h want %h", pc_plus4, 64'h0);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (pc !== 64'h0)
      $display("FAIL wrap_pc got %h want %h", pc, 64'h0);
    else n_pass++;
  endtask

  task automatic test_halt();
    int bad;
    goto_pc(64'h20);
    halt = 1'b1;
    @(negedge clk);
    n_total++;
    if (pc !== 64'h20 || halted !== 1'b1 || fetch_valid !== 1'b0)
      $display("FAIL halt_enter got pc=%h h=%b fv=%b want 20 1 0",
               pc, halted, fetch_valid);
    else n_pass++;
    clear_ctl();
    br_reg     = 1'b1;
    reg_target = 64'h800;
    br_taken   = 1'b1;
    br_offset  = 64'h7;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pc !== 64'h20 || halted !== 1'b1 || fetch_valid !== 1'b0)
        bad++;
    end
    n_total++;
    if (bad != 0)
      $display("FAIL halt_hold got %0d bad cycles want 0 (pc=%h)",
               bad, pc);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++;
    if (pc !== 64'h0 || halted !== 1'b0 || fetch_valid !== 1'b0)
      $display("FAIL async_rst got pc=%h h=%b fv=%b want 0 0 0",
               pc, halted, fetch_valid);
    else n_pass++;
    @(negedge clk);
    clear_ctl();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (pc !== 64'h4 || fetch_valid !== 1'b1)
      $display("FAIL rst_resume got pc=%h fv=%b want 4 1",
               pc, fetch_valid);
    else n_pass++;
  endtask

  task automatic test_halt_stall();
    apply_reset();
    @(negedge clk);
    halt  = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    clear_ctl();
    n_total++;
    if (halted !== 1'b1 || pc !== 64'h0)
      $display("FAIL halt_stall got h=%b pc=%h want 1 0", halted, pc);
    else n_pass++;
  endtask

  task automatic test_boot_halt();
    apply_reset();
    halt = 1'b1;
    @(negedge clk);
    clear_ctl();
    n_total++;
    if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 64'h0)
      $display("FAIL boot_halt got h=%b fv=%b pc=%h want 1 0 0",
               halted, fetch_valid, pc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (halted !== 1'b1 || pc !== 64'h0)
      $display("FAIL boot_halt2 got h=%b pc=%h want 1 0", halted, pc);
    else n_pass++;
  endtask

  task automatic test_misalign();
    apply_reset();
    @(negedge clk);
    goto_pc(64'h40);
    br_reg     = 1'b1;
    reg_target = 64'h803;
    @(negedge clk);
    clear_ctl();
`ifdef PC_MISALIGN_TRAP_EN
    n_total++;
    if (halted !== 1'b1 || misalign_err !== 1'b1 || pc !== 64'h40)
      $display("FAIL misalign got h=%b err=%b pc=%h want 1 1 40",
               halted, misalign_err, pc);
    else n_pass++;
`else
    n_total++;
    if (pc !== 64'h800 || halted !== 1'b0)
      $display("FAIL misalign got pc=%h h=%b want 800 0", pc, halted);
    else n_pass++;
`endif
  endtask

  initial begin
    reset = 1'b0;
    clear_ctl();
    test_reset();
    test_boot();
    test_boot_ignore();
    test_branch();
    test_priority();
    test_wrap();
    test_halt();
    test_halt_stall();
    test_boot_halt();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
